// File: rtl/fir_tdm_multiband_if.sv
// Sample, coefficient-write and result signals of the multiband TDM FIR.
interface fir_tdm_multiband_if #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned COEF_W = 10,
  parameter int unsigned TAPS   = 30,
  parameter int unsigned BANDS  = 4
);
  localparam int unsigned BAND_W = (BANDS > 1) ? $clog2(BANDS) : 1;
  localparam int unsigned ADDR_W = $clog2(TAPS);

  logic [DATA_W-1:0] fir_in;
  logic              in_valid;
  logic              in_ready;
  logic [BAND_W-1:0] band_sel;
  logic              coef_we;
  logic [BAND_W-1:0] coef_band;
  logic [ADDR_W-1:0] coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              coef_err;
  logic [DATA_W-1:0] fir_out;
  logic              out_valid;

  modport master (
    output fir_in, in_valid, band_sel, coef_we, coef_band, coef_addr, coef_data,
    input  in_ready, coef_err, fir_out, out_valid
  );

  modport slave (
    input  fir_in, in_valid, band_sel, coef_we, coef_band, coef_addr, coef_data,
    output in_ready, coef_err, fir_out, out_valid
  );
endinterface

// File: rtl/fir_tdm_multiband.sv
// Time-multiplexed FIR: one multiply-accumulate per cycle over a circular
// history, BANDS programmable coefficient sets, sign-magnitude in and out.
module fir_tdm_multiband #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned COEF_W = 10,
  parameter int unsigned TAPS   = 30,
  parameter int unsigned BANDS  = 4
) (
  input  logic               clk_slow,
  input  logic               rst,
  fir_tdm_multiband_if.slave bus
);
  localparam int unsigned BAND_W = (BANDS > 1) ? $clog2(BANDS) : 1;
  localparam int unsigned ADDR_W = $clog2(TAPS);
  localparam int unsigned MAG_W  = DATA_W - 1;
  localparam int unsigned PROD_W = DATA_W + COEF_W - 1;
  localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS);
  localparam logic [ADDR_W-1:0]       LAST_TAP = ADDR_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_POS  = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_NEG  = -SAT_POS;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0]        hist [TAPS];
  logic [COEF_W-1:0]        coef [BANDS][TAPS];
  logic [ADDR_W-1:0]        wptr, rptr, tap;
  logic [BAND_W-1:0]        band_q;
  logic signed [ACC_W-1:0]  acc;

  logic                     accept_c, mac_en_c, out_load_c;
  logic                     coef_ok_c, coef_wr_c, coef_drop_c;
  logic signed [DATA_W-1:0] x_tc_c;
  logic signed [COEF_W-1:0] c_tc_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  scaled_c;
  logic [DATA_W-1:0]        res_c;

  // Sign-magnitude to two's complement; -0 folds to 0.
  function automatic logic signed [DATA_W-1:0] data_to_tc(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] mag;
    mag = {1'b0, v[DATA_W-2:0]};
    return v[DATA_W-1] ? $signed(-mag) : $signed(mag);
  endfunction

  function automatic logic signed [COEF_W-1:0] coef_to_tc(input logic [COEF_W-1:0] v);
    logic [COEF_W-1:0] mag;
    mag = {1'b0, v[COEF_W-2:0]};
    return v[COEF_W-1] ? $signed(-mag) : $signed(mag);
  endfunction

  // State register.
  always_ff @(posedge clk_slow) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: accept in IDLE, TAPS MAC cycles, one OUT cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = MAC;
      MAC:     if (tap == LAST_TAP) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control strobes decoded from the current state.
  always_comb begin
    accept_c   = 1'b0;
    mac_en_c   = 1'b0;
    out_load_c = 1'b0;
    case (state)
      IDLE:    accept_c   = bus.in_valid;
      MAC:     mac_en_c   = 1'b1;
      OUT:     out_load_c = 1'b1;
      default: ;
    endcase
    coef_ok_c   = (32'(bus.coef_addr) < TAPS) && (32'(bus.coef_band) < BANDS);
    coef_wr_c   = bus.coef_we && coef_ok_c && (state == IDLE);
    coef_drop_c = bus.coef_we && coef_ok_c && (state != IDLE);
  end

  // Current tap product.
  always_comb begin
    x_tc_c = data_to_tc(hist[rptr]);
    c_tc_c = coef_to_tc(coef[band_q][tap]);
    prod_c = PROD_W'(x_tc_c) * PROD_W'(c_tc_c);
  end

  // Scale by the coefficient binary point (floor), saturate, back to sign-magnitude.
  always_comb begin
    scaled_c = acc >>> (COEF_W - 1);
    if (scaled_c > SAT_POS)     res_c = {1'b0, MAG_W'(SAT_POS)};
    else if (scaled_c < SAT_NEG) res_c = {1'b1, MAG_W'(SAT_POS)};
    else if (scaled_c[ACC_W-1])  res_c = {1'b1, MAG_W'(-scaled_c)};
    else                         res_c = {1'b0, MAG_W'(scaled_c)};
  end

  // Datapath, coefficient store and registered outputs.
  always_ff @(posedge clk_slow) begin
    if (rst) begin
      for (int t = 0; t < TAPS; t++) hist[t] <= '0;
      for (int b = 0; b < BANDS; b++)
        for (int t = 0; t < TAPS; t++) coef[b][t] <= '0;
      wptr          <= '0;
      rptr          <= '0;
      tap           <= '0;
      band_q        <= '0;
      acc           <= '0;
      bus.fir_out   <= '0;
      bus.out_valid <= 1'b0;
      bus.coef_err  <= 1'b0;
      bus.in_ready  <= 1'b1;
    end else begin
      bus.out_valid <= out_load_c;
      bus.coef_err  <= coef_drop_c;
      bus.in_ready  <= (state_nxt == IDLE);
      if (coef_wr_c) coef[bus.coef_band][bus.coef_addr] <= bus.coef_data;
      if (accept_c) begin
        hist[wptr] <= bus.fir_in;
        band_q     <= bus.band_sel;
        acc        <= '0;
        rptr       <= wptr;
        tap        <= '0;
        wptr       <= (wptr == LAST_TAP) ? '0 : wptr + ADDR_W'(1);
      end
      if (mac_en_c) begin
        acc  <= acc + ACC_W'(prod_c);
        tap  <= tap + ADDR_W'(1);
        rptr <= (rptr == '0) ? LAST_TAP : rptr - ADDR_W'(1);
      end
      if (out_load_c) bus.fir_out <= res_c;
    end
  end
endmodule

// File: tb/tb_fir_tdm_multiband.sv
// Scoreboard bench for fir_tdm_multiband against an arithmetic FIR model.
module tb_fir_tdm_multiband;
  localparam int unsigned DATA_W = 10;
  localparam int unsigned COEF_W = 10;
  localparam int unsigned TAPS   = 30;
  localparam int unsigned BANDS  = 4;
  localparam int unsigned BAND_W = 2;
  localparam int unsigned ADDR_W = 5;

  typedef struct {
    int val;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  exp_t sb[$];
  int   cerr_q[$];
  int   hist_q[$];
  int   mcoef[BANDS][TAPS];
  int   cyc = 0;
  int   last_t = -1000;
  bit   last_acc;
  int   exp_hold = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_tdm_multiband_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .BANDS(BANDS)) bus ();

  fir_tdm_multiband #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .BANDS(BANDS)) dut (
    .clk_slow (clk),
    .rst      (rst),
    .bus      (bus)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int sm2int(input int v, input int w);
    int mag;
    mag = v & ((1 << (w - 1)) - 1);
    return ((v >> (w - 1)) & 1) ? -mag : mag;
  endfunction

  // Engine is occupied for the TAPS+1 edges following an acceptance.
  function automatic bit busy(input int e);
    return (e > last_t) && (e <= last_t + int'(TAPS) + 1);
  endfunction

  // y = floor(sum(c*x) / 2^(COEF_W-1)), saturated, encoded sign-magnitude.
  function automatic int model_out(input int band);
    longint acc;
    longint q;
    longint div;
    int     sat;
    int     y;
    acc = 0;
    div = longint'(1) << (COEF_W - 1);
    sat = (1 << (DATA_W - 1)) - 1;
    for (int k = 0; k < int'(TAPS); k++)
      if (k < hist_q.size()) acc += longint'(mcoef[band][k]) * longint'(hist_q[k]);
    q = acc / div;
    if (acc < 0 && q * div != acc) q -= 1;
    if (q > sat) q = sat;
    if (q < -sat) q = -sat;
    y = int'(q);
    return (y < 0) ? ((1 << (DATA_W - 1)) | -y) : y;
  endfunction

  // One clock of stimulus; the model decides what the next edge does.
  task automatic step(input bit v, input int x, input int band,
                      input bit we, input int cb, input int ca, input int cd);
    int   e;
    bit   idle;
    exp_t t;
    @(negedge clk);
    e    = cyc + 1;
    idle = !busy(e);
    check("in_ready", int'(bus.in_ready), int'(idle));
    bus.in_valid  = v;
    bus.fir_in    = DATA_W'(x);
    bus.band_sel  = BAND_W'(band);
    bus.coef_we   = we;
    bus.coef_band = BAND_W'(cb);
    bus.coef_addr = ADDR_W'(ca);
    bus.coef_data = COEF_W'(cd);
    last_acc = 1'b0;
    if (we && ca < int'(TAPS)) begin
      if (idle) mcoef[cb][ca] = sm2int(cd, COEF_W);
      else      cerr_q.push_back(e);
    end
    if (v && idle) begin
      hist_q.push_front(sm2int(x, DATA_W));
      if (hist_q.size() > int'(TAPS)) void'(hist_q.pop_back());
      last_t = e;
      t.val  = model_out(band);
      t.due  = e + int'(TAPS) + 1;
      sb.push_back(t);
      last_acc = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0, 1'b0, 0, 0, 0);
  endtask

  task automatic write_coef(input int b, input int a, input int d);
    step(1'b0, 0, 0, 1'b1, b, a, d);
  endtask

  // Holds in_valid until the sample is taken.
  task automatic send(input int x, input int band);
    int guard;
    guard = 0;
    do begin
      step(1'b1, x, band, 1'b0, 0, 0, 0);
      guard++;
    end while (!last_acc && guard < 200);
    if (!last_acc) begin
      checks++;
      errors++;
      $display("FAIL send: sample 0x%0h not accepted within 200 cycles", x);
    end
  endtask

  // Reset with in_valid and coef_we asserted to exercise reset priority.
  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.fir_in    = DATA_W'(256);
    bus.band_sel  = '0;
    bus.coef_we   = 1'b1;
    bus.coef_band = '0;
    bus.coef_addr = '0;
    bus.coef_data = COEF_W'(256);
    @(negedge clk);
    check("rst_fir_out", int'(bus.fir_out), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_coef_err", int'(bus.coef_err), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    sb.delete();
    cerr_q.delete();
    hist_q.delete();
    foreach (mcoef[b, t]) mcoef[b][t] = 0;
    last_t       = -1000;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
  endtask

  // Monitor: pops expected results and coef_err pulses as the DUT presents them.
  initial begin
    exp_t ex;
    int   ec;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        exp_hold = 0;
      end else begin
        if (bus.out_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_valid: unexpected pulse, fir_out 0x%0h (cycle %0d)", bus.fir_out, cyc);
          end else begin
            ex = sb.pop_front();
            check("fir_out", int'(bus.fir_out), ex.val);
            check("latency", cyc, ex.due);
            exp_hold = ex.val;
          end
        end else begin
          check("hold", int'(bus.fir_out), exp_hold);
        end
        if (bus.coef_err) begin
          if (cerr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL coef_err: unexpected pulse (cycle %0d)", cyc);
          end else begin
            ec = cerr_q.pop_front();
            check("coef_err_cycle", cyc, ec);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.fir_in    = '0;
    bus.band_sel  = '0;
    bus.coef_we   = 1'b0;
    bus.coef_band = '0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    do_reset();

    // Impulse through band 0 with c[2] = 0.5.
    write_coef(0, 2, 'h100);
    send('h100, 0);
    repeat (4) send(0, 0);

    // Negative coefficient.
    write_coef(1, 0, 'h300);
    send('h100, 1);

    // Saturation both ways.
    for (int k = 0; k < int'(TAPS); k++) write_coef(2, k, 'h1FF);
    repeat (TAPS) send('h1FF, 2);
    repeat (TAPS) send('h3FF, 2);

    // in_valid held high continuously.
    for (int i = 0; i < 4 * int'(TAPS + 2); i++)
      step(1'b1, int'($urandom_range(0, 1023)), 0, 1'b0, 0, 0, 0);
    idle(TAPS + 2);

    // Coefficient writes while busy are dropped; out-of-range address is silent.
    send('h100, 3);
    idle(5);
    write_coef(3, 0, 'h100);
    write_coef(3, 30, 'h100);
    idle(TAPS);
    write_coef(0, 31, 'h1FF);
    send('h100, 3);
    idle(TAPS + 2);
    step(1'b1, 'h100, 3, 1'b1, 3, 0, 'h100);
    idle(TAPS + 2);

    // Reset in the middle of MAC aborts the sample.
    send('h155, 0);
    idle(10);
    do_reset();
    idle(TAPS + 4);
    send('h100, 0);
    idle(TAPS + 2);

    // Random traffic: samples, bands, gaps and coefficient writes at any time.
    for (int i = 0; i < 120; i++) begin
      int cd;
      if ($urandom_range(0, 2) == 0) begin
        cd = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1023))
                                         : (int'($urandom_range(0, 1)) << 9) | int'($urandom_range(0, 40));
        write_coef(int'($urandom_range(0, BANDS - 1)), int'($urandom_range(0, 31)), cd);
      end
      send(int'($urandom_range(0, 1023)), int'($urandom_range(0, BANDS - 1)));
      idle(int'($urandom_range(0, 40)));
    end

    idle(TAPS + 5);
    check("sb_drain", sb.size(), 0);
    check("coef_err_drain", cerr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
